// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: oldest-first arbitration of ALU and LSU writebacks onto the single register-file write port
module reg_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] WriteData,
    output logic              busy
);
    logic              aluHoldValid, lsuHoldValid, lsuOlder;
    logic [ADDR_W-1:0] aluHoldAddr, lsuHoldAddr, grantAddr;
    logic [DATA_W-1:0] aluHoldData, lsuHoldData, grantData;
    logic              grantAlu, grantLsu, anyGrant, aluAcc, lsuAcc;

    always_comb begin
        grantLsu  = lsuHoldValid & (!aluHoldValid | lsuOlder);
        grantAlu  = aluHoldValid & (!lsuHoldValid | !lsuOlder);
        anyGrant  = grantAlu | grantLsu;
        grantAddr = grantLsu ? lsuHoldAddr : aluHoldAddr;
        grantData = grantLsu ? lsuHoldData : aluHoldData;
        alu_ready = !aluHoldValid | grantAlu;
        lsu_ready = !lsuHoldValid | grantLsu;
        aluAcc    = alu_valid & alu_ready;
        lsuAcc    = lsu_valid & lsu_ready;
        busy      = aluHoldValid | lsuHoldValid;
    end

    // A new ALU entry is never older than a held LSU entry; a simultaneous fill also favours the LSU.
    // When only the LSU fills, any surviving ALU entry is older; otherwise age is irrelevant or unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aluHoldValid <= 1'b0;
            lsuHoldValid <= 1'b0;
            aluHoldAddr  <= '0;
            lsuHoldAddr  <= '0;
            aluHoldData  <= '0;
            lsuHoldData  <= '0;
            lsuOlder     <= 1'b0;
            RegWrite     <= 1'b0;
            WriteAddr    <= '0;
            WriteData    <= '0;
        end else begin
            aluHoldValid <= aluAcc | (aluHoldValid & !grantAlu);
            lsuHoldValid <= lsuAcc | (lsuHoldValid & !grantLsu);
            if (aluAcc) begin
                aluHoldAddr <= alu_addr;
                aluHoldData <= alu_data;
            end
            if (lsuAcc) begin
                lsuHoldAddr <= lsu_addr;
                lsuHoldData <= lsu_data;
            end
            lsuOlder <= aluAcc ? 1'b1 : lsuAcc ? 1'b0 : lsuOlder;
            RegWrite <= anyGrant && (grantAddr != '0);
            if (anyGrant) begin
                WriteAddr <= grantAddr;
                WriteData <= grantData;
            end
        end
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: random and directed writeback traffic scored against an age-stamped slot model
module tb_reg_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [AW-1:0] alu_addr = '0, lsu_addr = '0;
    logic [DW-1:0] alu_data = '0, lsu_data = '0;
    logic          alu_ready, lsu_ready, RegWrite, busy;
    logic [AW-1:0] WriteAddr;
    logic [DW-1:0] WriteData;

    reg_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            edgeNo;
    } wr_t;

    wr_t           expQ[$];
    int            checks = 0, errors = 0, edges = 0, stampCtr = 0;
    bit            mValid[2];
    logic [AW-1:0] mAddr[2];
    logic [DW-1:0] mData[2];
    int            mStamp[2];

    always @(posedge clk) edges <= edges + 1;

    // Monitor: every register-file write must be the next expected one, on the expected edge
    always @(posedge clk) begin : mon
        wr_t e;
        #1;
        if (RegWrite) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h at edge %0d, expected no write", WriteAddr, WriteData, edges);
            end else begin
                e = expQ.pop_front();
                if (WriteAddr !== e.addr || WriteData !== e.data || edges != e.edgeNo) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h edge=%0d, expected addr=%0d data=%h edge=%0d",
                             WriteAddr, WriteData, edges, e.addr, e.data, e.edgeNo);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, check ready/busy against the model, then advance the model across the edge
    task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                        output bit aAcc, output bit lAcc);
        int  g;
        bit  r0, r1;
        wr_t w;
        @(negedge clk);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        #1;
        g = -1;
        if (mValid[0] && mValid[1]) g = (mStamp[0] < mStamp[1]) ? 0 : 1;
        else if (mValid[0]) g = 0;
        else if (mValid[1]) g = 1;
        r0 = !mValid[0] || g == 0;
        r1 = !mValid[1] || g == 1;
        chk("alu_ready", 64'(alu_ready), 64'(r0));
        chk("lsu_ready", 64'(lsu_ready), 64'(r1));
        chk("busy", 64'(busy), 64'(mValid[0] | mValid[1]));
        if (g >= 0) begin
            if (mAddr[g] != '0) begin
                w.addr = mAddr[g]; w.data = mData[g]; w.edgeNo = edges + 1;
                expQ.push_back(w);
            end
            mValid[g] = 1'b0;
        end
        lAcc = lv && r1;
        aAcc = av && r0;
        if (lAcc) begin
            mValid[1] = 1'b1; mAddr[1] = la; mData[1] = ld; mStamp[1] = stampCtr; stampCtr++;
        end
        if (aAcc) begin
            mValid[0] = 1'b1; mAddr[0] = aa; mData[0] = ad; mStamp[0] = stampCtr; stampCtr++;
        end
    endtask

    task automatic idle(input int n);
        bit a, l;
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, a, l);
    endtask

    task automatic checkCleared(input string tag);
        chk({tag, "_RegWrite"}, 64'(RegWrite), 64'd0);
        chk({tag, "_WriteAddr"}, 64'(WriteAddr), 64'd0);
        chk({tag, "_WriteData"}, 64'(WriteData), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit a, l;
        int aCnt, lCnt;
        repeat (2) @(negedge clk);
        checkCleared("reset");
        rst = 1'b1;

        // Single ALU write, two edges after acceptance
        step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, a, l);
        idle(3);

        // Simultaneous requests to the same register: LSU first
        step(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, a, l);
        idle(3);

        // Both streaming until each has delivered eight entries
        aCnt = 0; lCnt = 0;
        for (int i = 0; i < 40 && (aCnt < 8 || lCnt < 8); i++) begin
            step(aCnt < 8, AW'(1 + aCnt), 32'h100 + aCnt, lCnt < 8, AW'(9 + lCnt), 32'h200 + lCnt, a, l);
            aCnt += int'(a);
            lCnt += int'(l);
        end
        chk("stream_alu_count", 64'(aCnt), 64'd8);
        chk("stream_lsu_count", 64'(lCnt), 64'd8);
        idle(3);

        // x0 write consumes a grant cycle without RegWrite
        step(1, 5'd0, 32'hFFFFFFFF, 0, '0, '0, a, l);
        step(0, '0, '0, 1, 5'd7, 32'h7, a, l);
        idle(3);

        // Reset with both slots full: discarded immediately, nothing written afterwards
        step(1, 5'd12, 32'hAAAA, 1, 5'd13, 32'hBBBB, a, l);
        @(negedge clk);
        alu_valid = 0; lsu_valid = 0;
        #2 rst = 1'b0;
        #1 checkCleared("midreset");
        mValid[0] = 1'b0; mValid[1] = 1'b0;
        expQ.delete();
        @(negedge clk);
        rst = 1'b1;
        idle(3);

        // LSU held, ALU filled a cycle later
        step(0, '0, '0, 1, 5'd20, 32'h2020, a, l);
        step(1, 5'd21, 32'h2121, 0, '0, '0, a, l);
        idle(3);

        // Random traffic including x0 and same-address collisions
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 2) != 0, AW'($urandom_range(0, 31)), $urandom, a, l);
        idle(6);
        chk("queue_drained", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
